// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle Moore control unit for the RISC-V OAC core, with req/ack memory phases and a ULA command decoder.
// Optional illegal-instruction trap state is built when ILLEGAL_INSN_TRAP_EN is defined.
module riscv_mc_ctrl #(
  parameter int ULA_CMD_W   = 3,
  parameter int ACK_TIMEOUT = 16,
  parameter int BNE_EN      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 func7b5,
  input  logic                 zero,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 d_mem_re,
  output logic                 d_mem_we,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 pc_src,
  output logic                 rf_we,
  output logic [1:0]           rf_src,
  output logic                 ula_src,
  output logic [ULA_CMD_W-1:0] ula_cmd,
  output logic                 bus_err,
  output logic [3:0]           state_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    RST      = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EX_R     = 4'd3,
    EX_I     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_MEM   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
`ifdef ILLEGAL_INSN_TRAP_EN
    , TRAP   = 4'd11
`endif
  } state_t;

`ifdef ILLEGAL_INSN_TRAP_EN
  localparam state_t ILL_ST = TRAP;
`else
  localparam state_t ILL_ST = FETCH;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             wait_st_s;
  logic             ack_s;
  logic             timeout_s;
  logic             bus_err_s;
  logic             branch_ok_s;
  logic [2:0]       cmd3_s;

  function automatic logic [2:0] ula_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    logic [2:0] cmd;
    case (op)
      7'b1100011: cmd = 3'b001;
      7'b0110011, 7'b0010011: begin
        case (f3)
          3'b000:  cmd = (f7 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  cmd = 3'b101;
          3'b100:  cmd = 3'b100;
          3'b110:  cmd = 3'b011;
          3'b111:  cmd = 3'b010;
          default: cmd = 3'b000;
        endcase
      end
      default: cmd = 3'b000;
    endcase
    return cmd;
  endfunction

  // Handshake qualifiers: the timeout is the cycle the counter reaches the limit; a same-cycle ack wins.
  always_comb begin
    wait_st_s   = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    ack_s       = (state_r == FETCH) ? imem_ack : dmem_ack;
    timeout_s   = (ACK_TIMEOUT != 0) && wait_st_s && (wait_cnt_r == CNT_W'(ACK_TIMEOUT));
    bus_err_s   = timeout_s && !ack_s;
    branch_ok_s = (func3 == 3'b000) || ((BNE_EN != 0) && (func3 == 3'b001));
  end

  // State register and wait counter; the counter only survives cycles spent waiting for an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RST;
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= (wait_st_s && !ack_s && !timeout_s) ? wait_cnt_r + CNT_W'(1) : '0;
      case (state_r)
        RST:    state_r <= FETCH;
        FETCH:  if (imem_ack) state_r <= DECODE;
        DECODE: begin
          case (opcode)
            7'b0110011:             state_r <= EX_R;
            7'b0010011:             state_r <= EX_I;
            7'b0000011, 7'b0100011: state_r <= MEM_ADDR;
            7'b1100011:             state_r <= branch_ok_s ? BRANCH : ILL_ST;
            7'b1101111:             state_r <= JAL;
            default:                state_r <= ILL_ST;
          endcase
        end
        MEM_ADDR: state_r <= opcode[5] ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (dmem_ack)       state_r <= WB_MEM;
          else if (timeout_s) state_r <= FETCH;
        end
        MEM_WR: if (dmem_ack || timeout_s) state_r <= FETCH;
        EX_R, EX_I, WB_MEM, BRANCH, JAL: state_r <= FETCH;
`ifdef ILLEGAL_INSN_TRAP_EN
        TRAP:   state_r <= TRAP;
`endif
        default: state_r <= RST;
      endcase
    end
  end

  // Output decode from state; requests drop in a timeout cycle that has no ack.
  always_comb begin
    imem_req = 1'b0;
    d_mem_re = 1'b0;
    d_mem_we = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    rf_we    = 1'b0;
    rf_src   = 2'b00;
    ula_src  = 1'b0;
    cmd3_s   = ula_dec(opcode, func3, func7b5);
    case (state_r)
      RST:    cmd3_s = 3'b000;
      FETCH: begin
        imem_req = !bus_err_s;
        ir_we    = imem_ack;
        pc_we    = imem_ack;
      end
      EX_R:     rf_we = 1'b1;
      EX_I: begin
        rf_we   = 1'b1;
        ula_src = 1'b1;
      end
      MEM_ADDR: ula_src = 1'b1;
      MEM_RD: begin
        ula_src  = 1'b1;
        d_mem_re = !bus_err_s;
      end
      MEM_WR: begin
        ula_src  = 1'b1;
        d_mem_we = !bus_err_s;
      end
      WB_MEM: begin
        rf_we  = 1'b1;
        rf_src = 2'b01;
      end
      BRANCH: begin
        pc_src = 1'b1;
        pc_we  = (func3 == 3'b001) ? !zero : zero;
      end
      JAL: begin
        rf_we  = 1'b1;
        rf_src = 2'b10;
        pc_we  = 1'b1;
        pc_src = 1'b1;
      end
`ifdef ILLEGAL_INSN_TRAP_EN
      TRAP:   cmd3_s = 3'b000;
`endif
      default: cmd3_s = cmd3_s;
    endcase
    ula_cmd = ULA_CMD_W'(cmd3_s);
    bus_err = bus_err_s;
    state_o = state_r;
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Table-driven bench for riscv_mc_ctrl: cycle-by-cycle vectors plus hand sequences for reset, trap and BNE_EN=0.
module tb_riscv_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7b5, zero, imem_ack, dmem_ack;

  logic       imem_req, d_mem_re, d_mem_we, ir_we, pc_we, pc_src, rf_we, ula_src, bus_err;
  logic [1:0] rf_src;
  logic [3:0] ula_cmd, state_o;

  logic       d2_imem_req, d2_d_mem_re, d2_d_mem_we, d2_ir_we, d2_pc_we, d2_pc_src, d2_rf_we, d2_ula_src, d2_bus_err;
  logic [1:0] d2_rf_src;
  logic [2:0] d2_ula_cmd;
  logic [3:0] d2_state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.ULA_CMD_W(4), .ACK_TIMEOUT(4), .BNE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7b5(func7b5), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .d_mem_re(d_mem_re),
    .d_mem_we(d_mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
    .rf_src(rf_src), .ula_src(ula_src), .ula_cmd(ula_cmd), .bus_err(bus_err), .state_o(state_o)
  );

  riscv_mc_ctrl #(.ULA_CMD_W(3), .ACK_TIMEOUT(0), .BNE_EN(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .opcode(opcode), .func3(func3), .func7b5(func7b5), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(d2_imem_req), .d_mem_re(d2_d_mem_re),
    .d_mem_we(d2_d_mem_we), .ir_we(d2_ir_we), .pc_we(d2_pc_we), .pc_src(d2_pc_src), .rf_we(d2_rf_we),
    .rf_src(d2_rf_src), .ula_src(d2_ula_src), .ula_cmd(d2_ula_cmd), .bus_err(d2_bus_err), .state_o(d2_state_o)
  );

  logic [18:0] out_w;
  assign out_w = {state_o, imem_req, d_mem_re, d_mem_we, ir_we, pc_we, pc_src, rf_we, rf_src, ula_src, ula_cmd, bus_err};

  // Flag fields: {imem_req, d_mem_re, d_mem_we, ir_we, pc_we, pc_src, rf_we, rf_src[1:0], ula_src}
  localparam logic [9:0] F_ACK  = 10'b100_110_0_00_0;
  localparam logic [9:0] F_WAIT = 10'b100_000_0_00_0;
  localparam logic [9:0] F_TO   = 10'b000_000_0_00_0;
  localparam logic [9:0] DEC    = 10'b000_000_0_00_0;
  localparam logic [9:0] EXR    = 10'b000_000_1_00_0;
  localparam logic [9:0] EXI    = 10'b000_000_1_00_1;
  localparam logic [9:0] MADR   = 10'b000_000_0_00_1;
  localparam logic [9:0] MRD    = 10'b010_000_0_00_1;
  localparam logic [9:0] MRD_TO = 10'b000_000_0_00_1;
  localparam logic [9:0] MWR    = 10'b001_000_0_00_1;
  localparam logic [9:0] WBM    = 10'b000_000_1_01_0;
  localparam logic [9:0] BR_T   = 10'b000_011_0_00_0;
  localparam logic [9:0] BR_N   = 10'b000_001_0_00_0;
  localparam logic [9:0] JALF   = 10'b000_011_1_10_0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7, z, ia, da;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                     input logic ia, input logic da, input logic [3:0] st, input logic [9:0] fl,
                     input logic [2:0] cmd, input logic be);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.ia = ia; v.da = da;
    v.exp = {st, fl, 1'b0, cmd, be};
    tbl.push_back(v);
  endtask

  task automatic alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [2:0] cmd);
    add(op, f3, f7, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, cmd, 1'b0);
    add(op, f3, f7, 1'b0, 1'b1, 1'b0, 4'd2, DEC, cmd, 1'b0);
    if (op == OP_R) add(op, f3, f7, 1'b0, 1'b1, 1'b0, 4'd3, EXR, cmd, 1'b0);
    else            add(op, f3, f7, 1'b0, 1'b1, 1'b0, 4'd4, EXI, cmd, 1'b0);
  endtask

  task automatic br(input logic [2:0] f3, input logic z, input logic [9:0] fl);
    add(OP_BR, f3, 1'b0, z, 1'b1, 1'b0, 4'd1, F_ACK, 3'b001, 1'b0);
    add(OP_BR, f3, 1'b0, z, 1'b1, 1'b0, 4'd2, DEC, 3'b001, 1'b0);
    add(OP_BR, f3, 1'b0, z, 1'b1, 1'b0, 4'd9, fl, 3'b001, 1'b0);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z,
                       input logic ia, input logic da);
    opcode = op; func3 = f3; func7b5 = f7; zero = z; imem_ack = ia; dmem_ack = da;
  endtask

  initial begin
    rst_n = 1'b0;
    rst2_n = 1'b0;
    drive(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);

    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 10'd0, 3'b000, 1'b0);
    alu(OP_R, 3'b000, 1'b0, 3'b000);
    alu(OP_R, 3'b000, 1'b1, 3'b001);
    alu(OP_I, 3'b000, 1'b1, 3'b000);
    alu(OP_I, 3'b100, 1'b0, 3'b100);
    alu(OP_R, 3'b111, 1'b0, 3'b010);
    alu(OP_R, 3'b110, 1'b0, 3'b011);
    alu(OP_R, 3'b010, 1'b0, 3'b101);
    alu(OP_R, 3'b011, 1'b1, 3'b000);
    // lw with dmem_ack on the 4th MEM_RD cycle
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, DEC, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, MADR, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, MRD, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 4'd6, MRD, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, WBM, 3'b000, 1'b0);
    // sw with immediate ack
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, 3'b000, 1'b0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, DEC, 3'b000, 1'b0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, MADR, 3'b000, 1'b0);
    add(OP_SW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7, MWR, 3'b000, 1'b0);
    br(3'b000, 1'b1, BR_T);
    br(3'b000, 1'b0, BR_N);
    br(3'b001, 1'b1, BR_N);
    br(3'b001, 1'b0, BR_T);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, 3'b000, 1'b0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, DEC, 3'b000, 1'b0);
    add(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, JALF, 3'b000, 1'b0);
    // fetch timeout in the 5th cycle, then a restart whose ack lands exactly on the limit
    for (int i = 0; i < 4; i++) add(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, F_WAIT, 3'b000, 1'b0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, F_TO, 3'b000, 1'b1);
    for (int i = 0; i < 4; i++) add(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, F_WAIT, 3'b000, 1'b0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, 3'b000, 1'b0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, DEC, 3'b000, 1'b0);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, EXR, 3'b000, 1'b0);
    // lw whose data handshake times out
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, F_ACK, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, DEC, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, MADR, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, MRD, 3'b000, 1'b0);
    add(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6, MRD_TO, 3'b000, 1'b1);
    add(OP_R, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, F_WAIT, 3'b000, 1'b0);

    repeat (3) @(negedge clk);
    #1 chk("reset", 32'(out_w), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].ia, tbl[i].da);
      #1 chk($sformatf("vec%0d", i), 32'(out_w), 32'(tbl[i].exp));
    end

    // Reset asserted while the fetch request is pending
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(out_w), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 chk("ill_rst", 32'(out_w), 32'd0);
    @(negedge clk); #1 chk("ill_fetch", 32'(out_w), 32'({4'd1, F_ACK, 5'd0}));
    @(negedge clk); #1 chk("ill_decode", 32'(out_w), 32'({4'd2, DEC, 5'd0}));
`ifdef ILLEGAL_INSN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1 chk($sformatf("trap%0d", i), 32'(out_w), 32'({4'd11, 15'd0}));
    end
    #2 rst_n = 1'b0;
    #1 chk("trap_rst", 32'(out_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1 chk("trap_exit", 32'(state_o), 32'd1);
`else
    @(negedge clk); #1 chk("ill_nop", 32'(out_w), 32'({4'd1, F_ACK, 5'd0}));
`endif

    // bne on the BNE_EN=0 instance is an unsupported branch
    @(negedge clk);
    rst2_n = 1'b1;
    drive(OP_BR, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("d2_rst", 32'(d2_state_o), 32'd0);
    @(negedge clk); #1 chk("d2_fetch", 32'(d2_state_o), 32'd1);
    @(negedge clk); #1 chk("d2_decode", 32'(d2_state_o), 32'd2);
    @(negedge clk);
`ifdef ILLEGAL_INSN_TRAP_EN
    #1 chk("d2_bne_unsup", 32'(d2_state_o), 32'd11);
`else
    #1 chk("d2_bne_unsup", 32'(d2_state_o), 32'd1);
`endif
    chk("d2_bne_pcwe", 32'(d2_pc_we & d2_pc_src), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
